pipeline_mem_stage: RTL and testbench



---
 rtl/pipeline_mem_stage_if.sv | 23 ++
 rtl/pipeline_mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_mem_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface pipeline_mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmemReq;
    logic              dmemWe;
    logic [ADDR_W-1:0] dmemAddr;
    logic [3:0]        dmemByteEn;
    logic [DATA_W-1:0] dmemWdata;
    logic [DATA_W-1:0] dmemRdata;
    logic              dmemAck;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemByteEn, dmemWdata,
        input  dmemRdata, dmemAck
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemByteEn, dmemWdata,
        output dmemRdata, dmemAck
    );
endinterface

// File: rtl/pipeline_mem_stage.sv
// DLX MEM stage: big-endian byte-lane steering, req/ack data-memory access,
// load extension and the MEM/WB pipeline register.
module pipeline_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 memHold,
    input  logic                 memKill,
    input  logic [DATA_W-1:0]    pc8In,
    input  logic [DATA_W-1:0]    aluOutIn,
    input  logic [4:0]           RwIn,
    input  logic [DATA_W-1:0]    busBIn,
    input  logic                 memWrIn,
    input  logic                 dExtOpIn,
    input  logic [1:0]           dSizeOpIn,
    input  logic                 jalIn,
    input  logic                 mem2regIn,
    input  logic                 regWrIn,
    pipeline_mem_stage_if.master dmem,
    output logic                 memStall,
    output logic [DATA_W-1:0]    wbData,
    output logic [4:0]           RwOut,
    output logic                 regWrOut,
    output logic                 misalignOut
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              killPend_q, killPend_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q;
    logic [1:0]        off_q;
    logic              isByte_q, isHalf_q, ext_q, load_q, regWr_q;
    logic [4:0]        rw_q;
    logic [DATA_W-1:0] aluOut_q, rdata_q;
    logic [DATA_W-1:0] wbData_q, wbData_d;
    logic [4:0]        rwOut_q, rwOut_d;
    logic              regWrOut_q, regWrOut_d;
    logic              misalign_q, misalign_d;

    logic [1:0]        off;
    logic              isByte, isHalf, isWord, isMemOp, misalign, startAccess;
    logic [7:0]        lane8;
    logic [15:0]       lane16;
    logic [DATA_W-1:0] loadData;

    assign off         = aluOutIn[1:0];
    assign isByte      = (dSizeOpIn == 2'b10);
    assign isHalf      = (dSizeOpIn == 2'b01);
    assign isWord      = !isByte && !isHalf;
    assign isMemOp     = memWrIn | mem2regIn;
    assign misalign    = isMemOp && ((isWord && off != 2'b00) || (isHalf && off[0]));
    assign startAccess = rst && (state_q == IDLE) && isMemOp && !misalign;

    assign memStall        = rst && (startAccess || state_q == REQ);
    assign dmem.dmemReq    = rst && (state_q == REQ);
    assign dmem.dmemWe     = we_q;
    assign dmem.dmemAddr   = addr_q;
    assign dmem.dmemByteEn = be_q;
    assign dmem.dmemWdata  = wdata_q;

    assign wbData      = wbData_q;
    assign RwOut       = rwOut_q;
    assign regWrOut    = regWrOut_q;
    assign misalignOut = misalign_q;

    // Lane 0 is the most significant byte (big-endian).
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = busBIn;
        if (isByte) begin
            be_d    = 4'b1000 >> off;
            wdata_d = {4{busBIn[7:0]}};
        end else if (isHalf) begin
            be_d    = off[1] ? 4'b0011 : 4'b1100;
            wdata_d = {2{busBIn[15:0]}};
        end
    end

    always_comb begin
        lane16 = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (off_q)
            2'd0:    lane8 = rdata_q[31:24];
            2'd1:    lane8 = rdata_q[23:16];
            2'd2:    lane8 = rdata_q[15:8];
            default: lane8 = rdata_q[7:0];
        endcase
        if (isByte_q)
            loadData = {{24{ext_q & lane8[7]}}, lane8};
        else if (isHalf_q)
            loadData = {{16{ext_q & lane16[15]}}, lane16};
        else
            loadData = rdata_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startAccess) state_d = REQ;
            REQ:     if (dmem.dmemAck) state_d = DONE;
            DONE:    if (!memHold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A kill seen mid-access cannot cancel the bus cycle, so remember it for DONE.
    always_comb begin
        killPend_d = killPend_q | (state_q == REQ && memKill);
        if (state_q == DONE && !memHold)
            killPend_d = 1'b0;
    end

    always_comb begin
        wbData_d   = wbData_q;
        rwOut_d    = rwOut_q;
        regWrOut_d = regWrOut_q;
        misalign_d = misalign_q;
        if (memKill || (state_q == DONE && killPend_q)) begin
            wbData_d   = '0;
            rwOut_d    = '0;
            regWrOut_d = 1'b0;
            misalign_d = 1'b0;
        end else if (!(memHold || memStall)) begin
            if (state_q == DONE) begin
                wbData_d   = load_q ? loadData : aluOut_q;
                rwOut_d    = rw_q;
                regWrOut_d = regWr_q;
                misalign_d = 1'b0;
            end else begin
                wbData_d   = jalIn ? pc8In : aluOutIn;
                rwOut_d    = RwIn;
                regWrOut_d = regWrIn && !misalign;
                misalign_d = misalign;
            end
        end
    end

    // Everything DONE needs is captured at access start, so upstream may move on.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            killPend_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            off_q      <= '0;
            isByte_q   <= 1'b0;
            isHalf_q   <= 1'b0;
            ext_q      <= 1'b0;
            load_q     <= 1'b0;
            regWr_q    <= 1'b0;
            rw_q       <= '0;
            aluOut_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            killPend_q <= killPend_d;
            if (startAccess) begin
                addr_q   <= {aluOutIn[ADDR_W-1:2], 2'b00};
                be_q     <= be_d;
                wdata_q  <= wdata_d;
                we_q     <= memWrIn;
                off_q    <= off;
                isByte_q <= isByte;
                isHalf_q <= isHalf;
                ext_q    <= dExtOpIn;
                load_q   <= mem2regIn && !memWrIn;
                regWr_q  <= regWrIn;
                rw_q     <= RwIn;
                aluOut_q <= aluOutIn;
            end
            if (state_q == REQ && dmem.dmemAck)
                rdata_q <= dmem.dmemRdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wbData_q   <= '0;
            rwOut_q    <= '0;
            regWrOut_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            wbData_q   <= wbData_d;
            rwOut_q    <= rwOut_d;
            regWrOut_q <= regWrOut_d;
            misalign_q <= misalign_d;
        end
    end
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Scoreboard bench for pipeline_mem_stage: bus and writeback expectations are
// queued when an instruction is driven and popped when the DUT produces them.
module tb_pipeline_mem_stage;
    logic        clk;
    logic        rst;
    logic        memHold, memKill;
    logic [31:0] pc8In, aluOutIn, busBIn;
    logic [4:0]  RwIn;
    logic        memWrIn, dExtOpIn, jalIn, mem2regIn, regWrIn;
    logic [1:0]  dSizeOpIn;
    logic        memStall, regWrOut, misalignOut;
    logic [31:0] wbData;
    logic [4:0]  RwOut;

    pipeline_mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dmemBus ();

    pipeline_mem_stage dut (
        .clk(clk), .rst(rst), .memHold(memHold), .memKill(memKill),
        .pc8In(pc8In), .aluOutIn(aluOutIn), .RwIn(RwIn), .busBIn(busBIn),
        .memWrIn(memWrIn), .dExtOpIn(dExtOpIn), .dSizeOpIn(dSizeOpIn),
        .jalIn(jalIn), .mem2regIn(mem2regIn), .regWrIn(regWrIn),
        .dmem(dmemBus.master), .memStall(memStall), .wbData(wbData),
        .RwOut(RwOut), .regWrOut(regWrOut), .misalignOut(misalignOut)
    );

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rw;
        logic        regWr;
        logic        mis;
        logic        chkData;
    } wbExp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chkW;
    } busExp_t;

    wbExp_t  wbQ[$];
    busExp_t busQ[$];
    wbExp_t  lastExp;
    int      testsRun = 0;
    int      testsFailed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expLoad(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [1:0] size, input logic ext);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        case (size)
            2'b10: begin
                sh = rdata >> (8 * (3 - int'(off)));
                b  = sh[7:0];
                return ext ? {{24{b[7]}}, b} : {24'h0, b};
            end
            2'b01: begin
                sh = rdata >> (8 * (2 - int'(off)));
                h  = sh[15:0];
                return ext ? {{16{h[15]}}, h} : {16'h0, h};
            end
            default: return rdata;
        endcase
    endfunction

    task automatic applyStimulus(
        input logic [31:0] pc8, input logic [31:0] alu, input logic [31:0] busB,
        input logic [4:0] rw, input logic memWr, input logic m2r, input logic ext,
        input logic [1:0] size, input logic jal, input logic regWr,
        input int ackDelay, input logic [31:0] rdata, input int holdCycles,
        input logic killInReq);
        wbExp_t  wexp;
        wbExp_t  got;
        busExp_t bexp;
        busExp_t bgot;
        logic [1:0] off;
        logic memOp, mis, finished, holdCheck;
        int stalls, reqs, cycles, holdLeft;

        off   = alu[1:0];
        memOp = memWr | m2r;
        mis   = memOp && ((size == 2'b01 && off[0]) ||
                          ((size == 2'b00 || size == 2'b11) && off != 2'b00));

        bexp.we   = memWr;
        bexp.addr = {alu[31:2], 2'b00};
        bexp.chkW = memWr;
        case (size)
            2'b10:   begin bexp.be = 4'(1 << (3 - int'(off))); bexp.wdata = {4{busB[7:0]}}; end
            2'b01:   begin bexp.be = 4'(3 << (2 - int'(off))); bexp.wdata = {2{busB[15:0]}}; end
            default: begin bexp.be = 4'b1111; bexp.wdata = busB; end
        endcase
        if (memOp && !mis) busQ.push_back(bexp);

        wexp.wb      = jal ? pc8 : (m2r && !memWr) ? expLoad(rdata, off, size, ext) : alu;
        wexp.rw      = rw;
        wexp.regWr   = regWr && !mis;
        wexp.mis     = mis;
        wexp.chkData = !mis;
        if (killInReq) begin
            wexp.wb    = '0;
            wexp.rw    = '0;
            wexp.regWr = 1'b0;
            wexp.mis   = 1'b0;
        end
        wbQ.push_back(wexp);

        pc8In = pc8; aluOutIn = alu; busBIn = busB; RwIn = rw; memWrIn = memWr;
        mem2regIn = m2r; dExtOpIn = ext; dSizeOpIn = size; jalIn = jal; regWrIn = regWr;

        stalls = 0; reqs = 0; cycles = 0; holdLeft = holdCycles; finished = 1'b0;
        while (!finished && cycles < 40) begin
            @(negedge clk);
            cycles++;
            holdCheck = 1'b0;
            if (memStall) stalls++;
            if (dmemBus.dmemReq) begin
                reqs++;
                if (reqs == 1) begin
                    if (busQ.size() == 0) begin
                        checkOutput("unexpectedReq", dmemBus.dmemReq, 1'b0);
                    end else begin
                        bgot = busQ.pop_front();
                        checkOutput("busAddr", dmemBus.dmemAddr, bgot.addr);
                        checkOutput("busWe", dmemBus.dmemWe, bgot.we);
                        checkOutput("busBe", dmemBus.dmemByteEn, bgot.be);
                        if (bgot.chkW) checkOutput("busWdata", dmemBus.dmemWdata, bgot.wdata);
                    end
                    if (killInReq) memKill = 1'b1;
                end
                if (reqs == ackDelay + 1) begin
                    dmemBus.dmemAck   = 1'b1;
                    dmemBus.dmemRdata = rdata;
                end
            end
            if (!memStall) begin
                if (holdLeft > 0) begin
                    memHold   = 1'b1;
                    holdLeft--;
                    holdCheck = 1'b1;
                end else begin
                    memHold  = 1'b0;
                    finished = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            dmemBus.dmemAck = 1'b0;
            memKill         = 1'b0;
            if (holdCheck) begin
                checkOutput("holdWb", wbData, lastExp.wb);
                checkOutput("holdRw", RwOut, lastExp.rw);
                checkOutput("holdRegWr", regWrOut, lastExp.regWr);
            end
        end
        memHold = 1'b0;
        if (!finished) checkOutput("timeout", cycles, 32'd0);

        got = wbQ.pop_front();
        if (got.chkData) begin
            checkOutput("wbData", wbData, got.wb);
            checkOutput("RwOut", RwOut, got.rw);
        end
        checkOutput("regWrOut", regWrOut, got.regWr);
        checkOutput("misalignOut", misalignOut, got.mis);
        checkOutput("stallCycles", stalls, (memOp && !mis) ? 2 + ackDelay : 0);
        checkOutput("reqCycles", reqs, (memOp && !mis) ? ackDelay + 1 : 0);
        lastExp = got;
    endtask

    initial begin
        int waitCnt;
        rst = 1'b0; memHold = 1'b0; memKill = 1'b0;
        dmemBus.dmemAck = 1'b0; dmemBus.dmemRdata = '0;
        // A load is presented during reset: the stage must neither stall nor request.
        pc8In = 32'h0; aluOutIn = 32'h100; busBIn = 32'h0; RwIn = 5'd4; memWrIn = 1'b0;
        mem2regIn = 1'b1; dExtOpIn = 1'b0; dSizeOpIn = 2'b00; jalIn = 1'b0; regWrIn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstStall", memStall, 1'b0);
        checkOutput("rstReq", dmemBus.dmemReq, 1'b0);
        checkOutput("rstWb", wbData, 32'h0);
        checkOutput("rstRw", RwOut, 5'd0);
        checkOutput("rstRegWr", regWrOut, 1'b0);
        checkOutput("rstMis", misalignOut, 1'b0);
        rst = 1'b1;

        //             pc8      alu       busB      rw  wr r  ext size  jal wr ack rdata   hold kill
        applyStimulus(32'h0,   32'h104,  32'h0,     5, 0, 1, 0, 2'b00, 0, 1, 1, 32'hDEADBEEF, 0, 0);
        applyStimulus(32'h0,   32'h22,   32'hA5,    3, 1, 0, 0, 2'b10, 0, 0, 0, 32'h0,        0, 0);
        applyStimulus(32'h0,   32'h42,   32'h0,     6, 0, 1, 1, 2'b01, 0, 1, 0, 32'h1234F00D, 0, 0);
        applyStimulus(32'h0,   32'h42,   32'h0,     7, 0, 1, 0, 2'b01, 0, 1, 2, 32'h1234F00D, 0, 0);
        applyStimulus(32'h0,   32'h41,   32'h0,     8, 0, 1, 1, 2'b10, 0, 1, 0, 32'h12803456, 0, 0);
        applyStimulus(32'h0,   32'h43,   32'h0,     9, 0, 1, 0, 2'b10, 0, 1, 1, 32'h12803496, 0, 0);
        applyStimulus(32'h0,   32'h46,   32'h1234BEEF, 10, 1, 0, 0, 2'b01, 0, 0, 0, 32'h0,   0, 0);
        applyStimulus(32'h0,   32'h80,   32'hCAFEF00D, 11, 1, 1, 0, 2'b00, 0, 0, 0, 32'h55555555, 0, 0);
        applyStimulus(32'h0,   32'h103,  32'h0,     5, 0, 1, 0, 2'b00, 0, 1, 0, 32'h0,        0, 0);
        applyStimulus(32'h0,   32'h45,   32'h0,     5, 1, 0, 0, 2'b01, 0, 0, 0, 32'h0,        0, 0);
        applyStimulus(32'h400, 32'h55,   32'h0,    31, 0, 0, 0, 2'b00, 1, 1, 0, 32'h0,        0, 0);
        applyStimulus(32'h0,   32'h1234, 32'h0,     7, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,        2, 0);
        applyStimulus(32'h0,   32'h300,  32'h0,    12, 0, 1, 0, 2'b00, 0, 1, 0, 32'h0BADF00D, 2, 0);
        applyStimulus(32'h0,   32'h304,  32'h0,    13, 0, 1, 0, 2'b00, 0, 1, 1, 32'h11111111, 0, 1);
        applyStimulus(32'h0,   32'h10,   32'h0,     2, 0, 1, 0, 2'b11, 0, 1, 0, 32'h87654321, 0, 0);

        // Reset while a load is in REQ, then a stray ack once back in IDLE.
        pc8In = 32'h0; aluOutIn = 32'h200; busBIn = 32'h0; RwIn = 5'd9; memWrIn = 1'b0;
        mem2regIn = 1'b1; dExtOpIn = 1'b0; dSizeOpIn = 2'b00; jalIn = 1'b0; regWrIn = 1'b1;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (!dmemBus.dmemReq && waitCnt < 10);
        checkOutput("midReqSeen", dmemBus.dmemReq, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midRstReq", dmemBus.dmemReq, 1'b0);
        checkOutput("midRstStall", memStall, 1'b0);
        checkOutput("midRstWb", wbData, 32'h0);
        checkOutput("midRstRegWr", regWrOut, 1'b0);
        aluOutIn = 32'h0; RwIn = 5'd0; mem2regIn = 1'b0; regWrIn = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        dmemBus.dmemAck   = 1'b1;
        dmemBus.dmemRdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        dmemBus.dmemAck = 1'b0;
        checkOutput("lateAckReq", dmemBus.dmemReq, 1'b0);
        checkOutput("lateAckStall", memStall, 1'b0);
        checkOutput("lateAckWb", wbData, 32'h0);
        checkOutput("lateAckRegWr", regWrOut, 1'b0);
        @(negedge clk);
        checkOutput("lateAckIdle", dmemBus.dmemReq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
